// File: rtl/fb_sched_pkg.sv
// Shared types and helpers for the frame-buffer burst scheduler.
package fb_sched_pkg;

    localparam int unsigned IDX_W = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARB  = 2'd1,
        ST_REQ  = 2'd2,
        ST_WAIT = 2'd3
    } state_e;

    function automatic logic [31:0] len_min(input logic [31:0] burst, input logic [31:0] remain);
        return (remain < burst) ? remain : burst;
    endfunction

    function automatic logic [63:0] buf_base(input logic [63:0] base, input logic [63:0] stride,
                                             input logic [IDX_W-1:0] idx);
        return base + (64'(idx) * stride);
    endfunction

endpackage

// File: rtl/fb_dir_cnt.sv
// Per-direction frame offset counter: next burst length and frame-complete status.
module fb_dir_cnt
    import fb_sched_pkg::*;
#(
    parameter int unsigned FRAME_WORDS = 384000,
    parameter int unsigned BURST_LEN   = 100,
    parameter int unsigned OFF_W       = 19
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             adv,
    output logic [OFF_W-1:0] off,
    output logic [7:0]       len_c,
    output logic             active_c
);

    logic [OFF_W-1:0] off_q, off_d;

    assign active_c = 32'(off_q) < FRAME_WORDS;
    assign len_c    = 8'(len_min(BURST_LEN, FRAME_WORDS - 32'(off_q)));
    assign off      = off_q;

    always_comb begin
        off_d = off_q;
        if (clr) begin
            off_d = '0;
        end else if (adv) begin
            off_d = off_q + OFF_W'(len_c);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            off_q <= '0;
        end else begin
            off_q <= off_d;
        end
    end

endmodule

// File: rtl/fb_burst_sched.sv
// Multi-buffer frame-store burst scheduler between capture/display FIFOs and the DDR app layer.
// Optional drop/repeat statistics counters enabled by defining FB_STATS_EN.
module fb_burst_sched
    import fb_sched_pkg::*;
#(
    parameter int unsigned ADDR_W      = 29,
    parameter int unsigned BASE_ADDR   = 0,
    parameter int unsigned BUF_STRIDE  = 524288,
    parameter int unsigned FRAME_WORDS = 384000,
    parameter int unsigned BURST_LEN   = 100,
    parameter int unsigned NUM_BUF     = 3,
    parameter int unsigned LVL_W       = 10
) (
    input  logic              clk,
    input  logic              sys_rst_n,
    input  logic              wr_frame_start,
    input  logic              rd_frame_start,
    input  logic [LVL_W-1:0]  wfifo_level,
    input  logic [LVL_W-1:0]  rfifo_level,
    output logic              cmd_valid,
    input  logic              cmd_ready,
    output logic              cmd_we,
    output logic [ADDR_W-1:0] cmd_addr,
    output logic [7:0]        cmd_len,
    input  logic              cmd_done,
    output logic [1:0]        wr_buf_idx,
    output logic [1:0]        rd_buf_idx,
    output logic [15:0]       drop_cnt,
    output logic [15:0]       repeat_cnt
);

    localparam int unsigned OFF_W      = $clog2(FRAME_WORDS + 1);
    localparam int unsigned FIFO_DEPTH = 32'(1) << LVL_W;

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  w_q, w_d, r_q, r_d, l_q, l_d, pick_w;
    logic              lv_q, lv_d;
    logic              wr_pend_q, wr_pend_d, rd_pend_q, rd_pend_d;
    logic              tie_rd_q, tie_rd_d;
    logic              cmd_valid_q, cmd_valid_d, cmd_we_q, cmd_we_d;
    logic [ADDR_W-1:0] cmd_addr_q, cmd_addr_d;
    logic [7:0]        cmd_len_q, cmd_len_d;
    logic              wr_clr, wr_adv, rd_clr, rd_adv;
    logic              wr_active, rd_active, wr_elig, rd_elig;
    logic [OFF_W-1:0]  wr_off, rd_off;
    logic [7:0]        wr_len, rd_len;
    logic [ADDR_W-1:0] wr_addr, rd_addr;

    fb_dir_cnt #(.FRAME_WORDS(FRAME_WORDS), .BURST_LEN(BURST_LEN), .OFF_W(OFF_W)) u_wr_cnt (
        .clk(clk), .rst_n(sys_rst_n), .clr(wr_clr), .adv(wr_adv),
        .off(wr_off), .len_c(wr_len), .active_c(wr_active)
    );

    fb_dir_cnt #(.FRAME_WORDS(FRAME_WORDS), .BURST_LEN(BURST_LEN), .OFF_W(OFF_W)) u_rd_cnt (
        .clk(clk), .rst_n(sys_rst_n), .clr(rd_clr), .adv(rd_adv),
        .off(rd_off), .len_c(rd_len), .active_c(rd_active)
    );

    assign wr_addr = ADDR_W'(buf_base(64'(BASE_ADDR), 64'(BUF_STRIDE), w_q) + 64'(wr_off));
    assign rd_addr = ADDR_W'(buf_base(64'(BASE_ADDR), 64'(BUF_STRIDE), r_q) + 64'(rd_off));
    assign wr_elig = wr_active && (32'(wfifo_level) >= 32'(wr_len));
    assign rd_elig = rd_active && ((FIFO_DEPTH - 32'(rfifo_level)) >= 32'(rd_len));

    // Next write buffer: lowest index clear of the one being published (current W) and of R.
    always_comb begin
        pick_w = '0;
        for (int i = int'(NUM_BUF) - 1; i >= 0; i--) begin
            if ((IDX_W'(i) != w_q) && ((NUM_BUF < 3) || (IDX_W'(i) != r_q))) begin
                pick_w = IDX_W'(i);
            end
        end
    end

`ifdef FB_STATS_EN
    logic [15:0] drop_cnt_q, drop_cnt_d, repeat_cnt_q, repeat_cnt_d;
`endif

    always_comb begin
        state_d     = state_q;
        w_d         = w_q;
        r_d         = r_q;
        l_d         = l_q;
        lv_d        = lv_q;
        wr_pend_d   = wr_pend_q | wr_frame_start;
        rd_pend_d   = rd_pend_q | rd_frame_start;
        tie_rd_d    = tie_rd_q;
        cmd_valid_d = cmd_valid_q;
        cmd_we_d    = cmd_we_q;
        cmd_addr_d  = cmd_addr_q;
        cmd_len_d   = cmd_len_q;
        wr_clr      = 1'b0;
        wr_adv      = 1'b0;
        rd_clr      = 1'b0;
        rd_adv      = 1'b0;
`ifdef FB_STATS_EN
        drop_cnt_d   = drop_cnt_q;
        repeat_cnt_d = repeat_cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                // Write event is applied first so a same-cycle read event sees the new publish.
                if (wr_pend_q) begin
                    wr_pend_d = wr_frame_start;
                    wr_clr    = 1'b1;
                    if (!wr_active) begin
                        l_d  = w_q;
                        lv_d = 1'b1;
                        w_d  = pick_w;
                    end
`ifdef FB_STATS_EN
                    if (wr_active && (drop_cnt_q != 16'hFFFF)) begin
                        drop_cnt_d = drop_cnt_q + 16'd1;
                    end
`endif
                end
                if (rd_pend_q) begin
                    rd_pend_d = rd_frame_start;
                    rd_clr    = 1'b1;
                    if (lv_d && (l_d != r_q)) begin
                        r_d = l_d;
                    end
`ifdef FB_STATS_EN
                    else if (lv_d && (repeat_cnt_q != 16'hFFFF)) begin
                        repeat_cnt_d = repeat_cnt_q + 16'd1;
                    end
`endif
                end
                state_d = ST_ARB;
            end
            ST_ARB: begin
                if (wr_elig && (!rd_elig || !tie_rd_q)) begin
                    cmd_we_d    = 1'b1;
                    cmd_addr_d  = wr_addr;
                    cmd_len_d   = wr_len;
                    cmd_valid_d = 1'b1;
                    state_d     = ST_REQ;
                    if (rd_elig) tie_rd_d = 1'b1;
                end else if (rd_elig) begin
                    cmd_we_d    = 1'b0;
                    cmd_addr_d  = rd_addr;
                    cmd_len_d   = rd_len;
                    cmd_valid_d = 1'b1;
                    state_d     = ST_REQ;
                    if (wr_elig) tie_rd_d = 1'b0;
                end else if (wr_pend_q || rd_pend_q) begin
                    // Nothing to issue: go apply pending frame events instead of stalling.
                    state_d = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (cmd_ready) begin
                    cmd_valid_d = 1'b0;
                    wr_adv      = cmd_we_q;
                    rd_adv      = !cmd_we_q;
                    state_d     = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cmd_done) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q     <= ST_IDLE;
            w_q         <= '0;
            r_q         <= '0;
            l_q         <= '0;
            lv_q        <= 1'b0;
            wr_pend_q   <= 1'b0;
            rd_pend_q   <= 1'b0;
            tie_rd_q    <= 1'b0;
            cmd_valid_q <= 1'b0;
            cmd_we_q    <= 1'b0;
            cmd_addr_q  <= '0;
            cmd_len_q   <= '0;
        end else begin
            state_q     <= state_d;
            w_q         <= w_d;
            r_q         <= r_d;
            l_q         <= l_d;
            lv_q        <= lv_d;
            wr_pend_q   <= wr_pend_d;
            rd_pend_q   <= rd_pend_d;
            tie_rd_q    <= tie_rd_d;
            cmd_valid_q <= cmd_valid_d;
            cmd_we_q    <= cmd_we_d;
            cmd_addr_q  <= cmd_addr_d;
            cmd_len_q   <= cmd_len_d;
        end
    end

`ifdef FB_STATS_EN
    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            drop_cnt_q   <= '0;
            repeat_cnt_q <= '0;
        end else begin
            drop_cnt_q   <= drop_cnt_d;
            repeat_cnt_q <= repeat_cnt_d;
        end
    end
    assign drop_cnt   = drop_cnt_q;
    assign repeat_cnt = repeat_cnt_q;
`else
    assign drop_cnt   = '0;
    assign repeat_cnt = '0;
`endif

    assign cmd_valid  = cmd_valid_q;
    assign cmd_we     = cmd_we_q;
    assign cmd_addr   = cmd_addr_q;
    assign cmd_len    = cmd_len_q;
    assign wr_buf_idx = w_q;
    assign rd_buf_idx = r_q;

endmodule

// File: tb/tb_fb_burst_sched.sv
// Scoreboard bench for fb_burst_sched: directed frame/burst scenarios with a DDR responder model.
module tb_fb_burst_sched;

    localparam int unsigned AW     = 29;
    localparam int unsigned FW     = 950;
    localparam int unsigned LW     = 10;
    localparam int unsigned STRIDE = 524288;
`ifdef FB_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          sys_rst_n;
    logic          wr_frame_start, rd_frame_start;
    logic [LW-1:0] wfifo_level, rfifo_level;
    logic          cmd_valid, cmd_ready, cmd_we, cmd_done;
    logic [AW-1:0] cmd_addr;
    logic [7:0]    cmd_len;
    logic [1:0]    wr_buf_idx, rd_buf_idx;
    logic [15:0]   drop_cnt, repeat_cnt;

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [7:0]    len;
    } cmd_t;

    cmd_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   hs_cnt = 0;
    logic slow_ready = 1'b0;
    logic hold_ready = 1'b0;

    fb_burst_sched #(
        .ADDR_W(AW), .BASE_ADDR(0), .BUF_STRIDE(STRIDE), .FRAME_WORDS(FW),
        .BURST_LEN(100), .NUM_BUF(3), .LVL_W(LW)
    ) dut (
        .clk(clk), .sys_rst_n(sys_rst_n),
        .wr_frame_start(wr_frame_start), .rd_frame_start(rd_frame_start),
        .wfifo_level(wfifo_level), .rfifo_level(rfifo_level),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_done(cmd_done),
        .wr_buf_idx(wr_buf_idx), .rd_buf_idx(rd_buf_idx),
        .drop_cnt(drop_cnt), .repeat_cnt(repeat_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push(input logic we, input int unsigned buf_i, input int unsigned off, input int unsigned len);
        cmd_t c;
        c.we   = we;
        c.addr = AW'(buf_i * STRIDE + off);
        c.len  = 8'(len);
        exp_q.push_back(c);
    endtask

    task automatic wait_hs(input int target, input string name);
        int n = 0;
        while (hs_cnt < target && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk(name, 64'(hs_cnt >= target), 64'd1);
    endtask

    task automatic wait_empty(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 600) begin
            @(negedge clk);
            n++;
        end
        chk(name, 64'(exp_q.size()), 64'd0);
    endtask

    task automatic pulse(input logic w, input logic r);
        wr_frame_start = w;
        rd_frame_start = r;
        @(negedge clk);
        wr_frame_start = 1'b0;
        rd_frame_start = 1'b0;
    endtask

    // DDR app ready: optionally stalls each command for two cycles, or holds it off entirely.
    initial begin
        int vcnt = 0;
        cmd_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (cmd_valid) vcnt++;
            else vcnt = 0;
            cmd_ready = !hold_ready && (!slow_ready || vcnt >= 3);
        end
    end

    // DDR completion: pulse cmd_done a few cycles after each accepted command.
    initial begin
        cmd_done = 1'b0;
        forever begin
            @(negedge clk);
            if (cmd_valid && cmd_ready && sys_rst_n) begin
                repeat (4) @(negedge clk);
                cmd_done = 1'b1;
                @(negedge clk);
                cmd_done = 1'b0;
            end
        end
    end

    // Monitor: pops expected commands on each handshake and checks stability under backpressure.
    initial begin
        cmd_t cur, prev, e;
        bit   prev_ok = 1'b0;
        forever begin
            @(negedge clk);
            if (!sys_rst_n || !cmd_valid) begin
                prev_ok = 1'b0;
            end else begin
                cur = {cmd_we, cmd_addr, cmd_len};
                if (prev_ok) chk("cmd_stable", 64'(cur), 64'(prev));
                if (cmd_ready) begin
                    hs_cnt++;
                    prev_ok = 1'b0;
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_cmd: got we=%0d addr=%0d len=%0d, expected no command",
                                 cmd_we, cmd_addr, cmd_len);
                    end else begin
                        e = exp_q.pop_front();
                        chk("cmd_we", 64'(cur.we), 64'(e.we));
                        chk("cmd_addr", 64'(cur.addr), 64'(e.addr));
                        chk("cmd_len", 64'(cur.len), 64'(e.len));
                    end
                end else begin
                    prev_ok = 1'b1;
                    prev    = cur;
                end
            end
        end
    end

    initial begin
        int base;
        int n;
        sys_rst_n      = 1'b0;
        wr_frame_start = 1'b0;
        rd_frame_start = 1'b0;
        wfifo_level    = '0;
        rfifo_level    = LW'(1023);
        repeat (3) @(negedge clk);
        chk("rst_cmd_valid", 64'(cmd_valid), 64'd0);
        chk("rst_cmd_we", 64'(cmd_we), 64'd0);
        chk("rst_cmd_addr", 64'(cmd_addr), 64'd0);
        chk("rst_cmd_len", 64'(cmd_len), 64'd0);
        chk("rst_wr_idx", 64'(wr_buf_idx), 64'd0);
        chk("rst_rd_idx", 64'(rd_buf_idx), 64'd0);
        chk("rst_drop", 64'(drop_cnt), 64'd0);
        chk("rst_repeat", 64'(repeat_cnt), 64'd0);
        sys_rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Read start before any publish: stays on buffer 0, not counted as a repeat.
        pulse(1'b0, 1'b1);
        for (int k = 0; k < 9; k++) push(1'b1, 0, k * 100, 100);
        push(1'b1, 0, 900, 50);
        wfifo_level = LW'(200);
        wait_empty("frame0_writes");
        repeat (40) @(negedge clk);
        chk("a_wr_idx", 64'(wr_buf_idx), 64'd0);
        chk("a_rd_idx", 64'(rd_buf_idx), 64'd0);
        chk("a_repeat", 64'(repeat_cnt), 64'd0);

        // Complete frame published: L=0, W=1, writes restart at buffer 1 base.
        for (int k = 0; k < 9; k++) push(1'b1, 1, k * 100, 100);
        push(1'b1, 1, 900, 50);
        pulse(1'b1, 1'b0);
        repeat (5) @(negedge clk);
        chk("b_wr_idx", 64'(wr_buf_idx), 64'd1);
        chk("b_rd_idx", 64'(rd_buf_idx), 64'd0);
        wait_empty("frame1_writes");
        repeat (20) @(negedge clk);
        wfifo_level = '0;
        chk("b_drop", 64'(drop_cnt), 64'd0);

        // Read start with L==R: repeat.
        pulse(1'b0, 1'b1);
        repeat (10) @(negedge clk);
        chk("c_rd_idx", 64'(rd_buf_idx), 64'd0);
        chk("c_repeat", 64'(repeat_cnt), STATS ? 64'd1 : 64'd0);

        // Frame starts during an in-flight read only take effect after cmd_done.
        base = hs_cnt;
        push(1'b0, 0, 0, 100);
        rfifo_level = '0;
        wait_hs(base + 1, "f_read_hs");
        rfifo_level = LW'(1023);
        pulse(1'b1, 1'b1);
        chk("f_hold_wr_idx", 64'(wr_buf_idx), 64'd1);
        chk("f_hold_rd_idx", 64'(rd_buf_idx), 64'd0);
        repeat (15) @(negedge clk);
        chk("f_wr_idx", 64'(wr_buf_idx), 64'd2);
        chk("f_rd_idx", 64'(rd_buf_idx), 64'd1);
        chk("f_repeat", 64'(repeat_cnt), STATS ? 64'd1 : 64'd0);

        // Partial frame then write start: dropped, W unchanged, restart at buffer base.
        base = hs_cnt;
        for (int k = 0; k < 5; k++) push(1'b1, 2, k * 100, 100);
        wfifo_level = LW'(200);
        wait_hs(base + 5, "d_writes_hs");
        wfifo_level = '0;
        repeat (20) @(negedge clk);
        pulse(1'b1, 1'b0);
        repeat (10) @(negedge clk);
        chk("d_wr_idx", 64'(wr_buf_idx), 64'd2);
        chk("d_drop", 64'(drop_cnt), STATS ? 64'd1 : 64'd0);
        push(1'b1, 2, 0, 100);
        wfifo_level = LW'(100);
        wait_hs(base + 6, "d_restart_hs");
        wfifo_level = '0;
        repeat (20) @(negedge clk);

        // Both directions eligible with a stalling DDR: strict write/read alternation.
        base = hs_cnt;
        push(1'b1, 2, 100, 100);
        push(1'b0, 1, 0, 100);
        push(1'b1, 2, 200, 100);
        push(1'b0, 1, 100, 100);
        push(1'b1, 2, 300, 100);
        push(1'b0, 1, 200, 100);
        slow_ready  = 1'b1;
        wfifo_level = LW'(1023);
        rfifo_level = '0;
        wait_hs(base + 6, "e_alt_hs");
        wfifo_level = '0;
        rfifo_level = LW'(1023);
        repeat (20) @(negedge clk);
        slow_ready = 1'b0;
        wait_empty("e_alt_drain");

        // Reset while a command is held in REQ: cmd_valid drops asynchronously.
        hold_ready  = 1'b1;
        wfifo_level = LW'(1023);
        n = 0;
        while (!cmd_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("g_valid_before_rst", 64'(cmd_valid), 64'd1);
        sys_rst_n = 1'b0;
        #1;
        chk("g_rst_valid", 64'(cmd_valid), 64'd0);
        chk("g_rst_addr", 64'(cmd_addr), 64'd0);
        chk("g_rst_wr_idx", 64'(wr_buf_idx), 64'd0);
        chk("g_rst_rd_idx", 64'(rd_buf_idx), 64'd0);
        chk("g_rst_drop", 64'(drop_cnt), 64'd0);
        wfifo_level = '0;
        hold_ready  = 1'b0;
        repeat (3) @(negedge clk);
        sys_rst_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("final_queue_empty", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
